instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 101 ++++++++++
 tb/tb_instr_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns decoded operation requests into 32-bit machine
// words and streams them, with sequential program addresses, to an
// instruction-memory writer through a single valid/ready output stage.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LW  = 3'd1,
    OP_SW  = 3'd2,
    OP_JMP = 3'd3
  } op_e;

  logic        accept;
  logic        out_fire;
  logic        legal;
  logic [31:0] enc;

  // Single output register: a new request can enter whenever the slot is
  // empty or is being drained this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Encode the request; only the fields the op uses reach the word.
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (in_op)
      OP_ADD:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd32};
      OP_LW:   enc = {6'd54, in_rs, in_rt, in_imm};
      OP_SW:   enc = {6'd55, in_rs, in_rt, in_imm};
      OP_JMP:  enc = {6'd2, in_target};
      default: legal = 1'b0;
    endcase
  end

  // Output stage: load on legal acceptance, otherwise empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end else if (accept && legal) begin
      out_valid <= 1'b1;
      out_instr <= enc;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Program address: the held word's address, advancing as each word drains,
  // so a word loaded in the draining cycle lands on the next address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= '0;
    end else if (clr) begin
      out_addr <= '0;
    end else if (out_fire) begin
      out_addr <= out_addr + ADDR_W'(1);
    end
  end

  // Illegal-op reporting: one-cycle pulse plus saturating tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed vectors, immediate asserts.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  int compared = 0;
  int failed   = 0;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    logic [7:0]  a;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;

    // reset state, held across a clock edge
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("post_release_valid", out_valid, 0);

    // single LW
    drive(3'd1, 5'd1, 5'd2, 5'd31, 16'd4, 26'h3ffffff);
    tick();
    chk("lw_valid", out_valid, 1);
    chk("lw_instr", out_instr, 32'hD8220004);
    chk("lw_addr", out_addr, 0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_addr", out_addr, 1);

    // clr restarts addressing
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_addr", out_addr, 0);

    // back-to-back SW / JMP / ADD with junk in unused fields
    drive(3'd2, 5'd3, 5'd4, 5'd31, 16'd4, 26'h3ffffff);
    tick();
    chk("sw_instr", out_instr, 32'hDC640004);
    chk("sw_addr", out_addr, 0);
    drive(3'd3, 5'd31, 5'd31, 5'd31, 16'hffff, 26'd4);
    tick();
    chk("jmp_instr", out_instr, 32'h08000004);
    chk("jmp_addr", out_addr, 1);
    drive(3'd0, 5'd5, 5'd6, 5'd7, 16'hffff, 26'h3ffffff);
    tick();
    chk("add_instr", out_instr, 32'h00A63820);
    chk("add_addr", out_addr, 2);
    chk("add_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain_valid", out_valid, 0);
    chk("b2b_drain_addr", out_addr, 3);

    // backpressure: word held, new request refused
    out_ready = 1'b0;
    drive(3'd1, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0);
    tick();
    chk("bp_load_instr", out_instr, 32'hD8220004);
    chk("bp_load_addr", out_addr, 3);
    drive(3'd0, 5'd9, 5'd9, 5'd9, 16'd0, 26'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_instr", out_instr, 32'hD8220004);
      chk("bp_addr", out_addr, 3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_addr", out_addr, 4);

    // illegal op
    drive(3'd5, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
    tick();
    chk("ill_err", err, 1);
    chk("ill_errcnt", err_count, 1);
    chk("ill_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("ill_err_pulse", err, 0);
    chk("ill_addr", out_addr, 4);
    drive(3'd0, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0);
    tick();
    chk("after_ill_addr", out_addr, 4);
    chk("after_ill_instr", out_instr, 32'h00A63820);

    // illegal concurrent with output handshake
    drive(3'd7, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick();
    chk("ill_hs_valid", out_valid, 0);
    chk("ill_hs_addr", out_addr, 5);
    chk("ill_hs_err", err, 1);
    chk("ill_hs_errcnt", err_count, 2);

    // saturation
    in_op = 3'd6;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_errcnt", err_count, 255);
    in_valid = 1'b0;
    tick();
    chk("sat_err_off", err, 0);
    chk("sat_addr", out_addr, 5);

    // clr clears tally; then 257 words wrap the address
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_errcnt", err_count, 0);
    chk("clr_addr2", out_addr, 0);
    for (int i = 0; i < 257; i++) begin
      a = i[7:0];
      drive(3'd0, 5'd0, 5'd0, a[4:0], 16'd0, 26'd0);
      tick();
      held = 32'd32 | (32'(a[4:0]) << 11);
      chk("wrap_addr", out_addr, a);
      chk("wrap_instr", out_instr, held);
    end

    // async reset mid-transfer
    drive(3'd4, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick();
    chk("pre_rst_errcnt", err_count, 1);
    chk("pre_rst_addr", out_addr, 1);
    drive(3'd1, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_addr", out_addr, 0);
    chk("arst_errcnt", err_count, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(3'd1, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0);
    tick();
    chk("post_rst_addr", out_addr, 0);
    chk("post_rst_instr", out_instr, 32'hD8220004);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
